// File: rtl/freq_meter_pkg.sv
// ---------------------------------------------------------------------------
// freq_meter_pkg
// Shared definitions for the frequency meter and its BCD converter:
//   - state_t         : measurement FSM states
//   - DEF_GATE_CYCLES : default gate window length in clk cycles (1 s @ 40 MHz)
//   - DEF_CNT_WIDTH   : default edge-counter width
//   - BCD_DIGITS      : number of packed BCD digits on the display path
// ---------------------------------------------------------------------------
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        CONV = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_GATE_CYCLES = 40_000_000;
    localparam int DEF_CNT_WIDTH   = 25;
    localparam int BCD_DIGITS      = 8;

endpackage

// File: rtl/freq_meter_bin2bcd.sv
// ---------------------------------------------------------------------------
// bin2bcd
// Sequential shift-add-3 (double-dabble) converter, one input bit per cycle.
// A load pulse captures bin; CNT_WIDTH cycles later done pulses for one cycle
// with the packed BCD result on bcd (digit 0 in bits [3:0]).
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (aborts a conversion)
//   load       : start a conversion of bin
//   bin        : binary value to convert
//   done       : one-cycle pulse, bcd valid
//   bcd        : BCD_DIGITS packed BCD digits
// ---------------------------------------------------------------------------
module bin2bcd
    import freq_meter_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [CNT_WIDTH-1:0]  bin,
    output logic                  done,
    output logic [31:0]           bcd
);

    localparam int BCD_W = 4 * BCD_DIGITS;
    localparam int SH_W  = $clog2(CNT_WIDTH + 1);

    logic [CNT_WIDTH-1:0] sh_q,   sh_d;
    logic [BCD_W-1:0]     bcd_q,  bcd_d;
    logic [SH_W-1:0]      left_q, left_d;
    logic                 run_q,  run_d;
    logic [BCD_W-1:0]     adj;

    // Add 3 to every digit >= 5 before the shift, so the shift carries
    // correctly into the next decimal digit.
    genvar gi;
    generate
        for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
            assign adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                    bcd_q[gi*4 +: 4] + 4'd3 : bcd_q[gi*4 +: 4];
        end
    endgenerate

    always_comb begin
        sh_d   = sh_q;
        bcd_d  = bcd_q;
        left_d = left_q;
        run_d  = run_q;
        if (load) begin
            sh_d   = bin;
            bcd_d  = '0;
            left_d = SH_W'(CNT_WIDTH);
            run_d  = 1'b1;
        end else if (run_q) begin
            if (left_q != '0) begin
                bcd_d  = {adj[BCD_W-2:0], sh_q[CNT_WIDTH-1]};
                sh_d   = sh_q << 1;
                left_d = left_q - SH_W'(1);
            end else begin
                run_d  = 1'b0;          // done pulses for exactly one cycle
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_q   <= '0;
            bcd_q  <= '0;
            left_q <= '0;
            run_q  <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            bcd_q  <= bcd_d;
            left_q <= left_d;
            run_q  <= run_d;
        end
    end

    assign done = run_q && (left_q == '0);
    assign bcd  = bcd_q;

endmodule

// File: rtl/freq_meter.sv
// ---------------------------------------------------------------------------
// freq_meter
// Counts rising edges of an asynchronous input over a GATE_CYCLES-long
// window and reports the count, optionally as packed BCD.
// Build option: define FREQ_METER_BCD_EN to add the CONV state and the
// bin2bcd converter; freq then carries 8 BCD digits (32 bits).
// Ports:
//   clk        : system clock
//   rst_n      : synchronous active-low reset
//   sig_in     : asynchronous signal under measurement
//   start      : one-cycle measurement request (ignored while busy / in DONE)
//   busy       : measurement in progress (GATE or CONV)
//   freq       : last result, held between freq_valid pulses
//   freq_valid : one-cycle pulse when freq/overflow update
//   overflow   : last result saturated
// ---------------------------------------------------------------------------
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
`ifdef FREQ_METER_BCD_EN
    localparam int FREQ_W     = 4 * BCD_DIGITS
`else
    localparam int FREQ_W     = CNT_WIDTH
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sig_in,
    input  logic              start,
    output logic              busy,
    output logic [FREQ_W-1:0] freq,
    output logic              freq_valid,
    output logic              overflow
);

    localparam int GC_W = $clog2(GATE_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t               state_q,    state_d;
    logic                 sync1_q,    sync1_d;
    logic                 sync2_q,    sync2_d;
    logic                 prev_q,     prev_d;
    logic [GC_W-1:0]      gate_cnt_q, gate_cnt_d;
    logic [CNT_WIDTH-1:0] cnt_q,      cnt_d;
    logic                 ovf_q,      ovf_d;
    logic [FREQ_W-1:0]    freq_q,     freq_d;
    logic                 overflow_q, overflow_d;
    logic                 rise;
    logic                 bcd_load;

`ifdef FREQ_METER_BCD_EN
    logic                 bcd_done;
    logic [31:0]          bcd_val;

    bin2bcd #(.CNT_WIDTH(CNT_WIDTH)) u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (bcd_load),
        .bin   (cnt_d),
        .done  (bcd_done),
        .bcd   (bcd_val)
    );
`endif

    always_comb begin
        state_d    = state_q;
        sync1_d    = sig_in;
        sync2_d    = sync1_q;
        prev_d     = sync2_q;
        gate_cnt_d = gate_cnt_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        freq_d     = freq_q;
        overflow_d = overflow_q;
        bcd_load   = 1'b0;
        rise       = sync2_q & ~prev_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    gate_cnt_d = '0;
                    cnt_d      = '0;
                    ovf_d      = 1'b0;
                    state_d    = GATE;
                end
            end
            GATE: begin
                gate_cnt_d = gate_cnt_q + GC_W'(1);
                if (rise) begin
                    if (cnt_q == CNT_MAX) ovf_d = 1'b1;
                    else                  cnt_d = cnt_q + CNT_WIDTH'(1);
                end
                // The edge seen in the last gate cycle is folded in through
                // cnt_d/ovf_d, so the result is complete at the transition.
                if (gate_cnt_q == GC_W'(GATE_CYCLES - 1)) begin
`ifdef FREQ_METER_BCD_EN
                    bcd_load   = 1'b1;
                    state_d    = CONV;
`else
                    freq_d     = cnt_d;
                    overflow_d = ovf_d;
                    state_d    = DONE;
`endif
                end
            end
`ifdef FREQ_METER_BCD_EN
            CONV: begin
                if (bcd_done) begin
                    freq_d     = ovf_q ? 32'h9999_9999 : bcd_val;
                    overflow_d = ovf_q;
                    state_d    = DONE;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;         // start in this cycle is dropped
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            prev_q     <= 1'b0;
            gate_cnt_q <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            freq_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            gate_cnt_q <= gate_cnt_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            freq_q     <= freq_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy       = (state_q == GATE) || (state_q == CONV);
    assign freq_valid = (state_q == DONE);
    assign freq       = freq_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_freq_meter.sv
// ---------------------------------------------------------------------------
// tb_freq_meter
// Two meters (wide counter / 800-cycle gate, and 4-bit counter / 200-cycle
// gate) driven with periodic, constant and random inputs. A timeline model
// predicts busy/freq_valid/freq/overflow every cycle from the input history.
// ---------------------------------------------------------------------------
module tb_freq_meter;

    localparam int NI = 2;
    localparam int G0 = 800;
    localparam int W0 = 25;
    localparam int G1 = 200;
    localparam int W1 = 4;
`ifdef FREQ_METER_BCD_EN
    localparam bit BCD = 1'b1;
    localparam int FW0 = 32;
    localparam int FW1 = 32;
`else
    localparam bit BCD = 1'b0;
    localparam int FW0 = W0;
    localparam int FW1 = W1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0] rst_n, start, sig, busy, fv, ovf;
    logic [FW0-1:0] f0;
    logic [FW1-1:0] f1;
    logic [31:0]    fq [NI];

    freq_meter #(.GATE_CYCLES(G0), .CNT_WIDTH(W0)) dut0 (
        .clk(clk), .rst_n(rst_n[0]), .sig_in(sig[0]), .start(start[0]),
        .busy(busy[0]), .freq(f0), .freq_valid(fv[0]), .overflow(ovf[0]));

    freq_meter #(.GATE_CYCLES(G1), .CNT_WIDTH(W1)) dut1 (
        .clk(clk), .rst_n(rst_n[1]), .sig_in(sig[1]), .start(start[1]),
        .busy(busy[1]), .freq(f1), .freq_valid(fv[1]), .overflow(ovf[1]));

    always_comb begin
        fq[0] = 32'(f0);
        fq[1] = 32'(f1);
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int gate_of(input int i);
        return (i == 0) ? G0 : G1;
    endfunction
    function automatic int width_of(input int i);
        return (i == 0) ? W0 : W1;
    endfunction
    // Clock edge (counted from the one that accepts start) at which the
    // result appears.
    function automatic int done_of(input int i);
        return BCD ? gate_of(i) + width_of(i) + 1 : gate_of(i);
    endfunction

    function automatic logic [31:0] to_bcd(input longint v);
        logic [31:0] r;
        longint      x;
        r = '0;
        x = v;
        for (int d = 0; d < 8; d++) begin
            r[d*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // ---------------- reference model ----------------
    bit          m_ok   [NI];
    bit          m_run  [NI];
    int          m_e    [NI];
    longint      m_cnt  [NI];
    bit          h1 [NI], h2 [NI], h3 [NI];
    bit          exp_busy [NI];
    bit          exp_fv   [NI];
    logic [31:0] exp_f    [NI];
    bit          exp_ovf  [NI];
    int          fv_count [NI];

    initial begin
        for (int i = 0; i < NI; i++) begin
            m_ok[i] = 0; m_run[i] = 0; m_e[i] = 0; m_cnt[i] = 0;
            h1[i] = 0; h2[i] = 0; h3[i] = 0;
            exp_busy[i] = 0; exp_fv[i] = 0; exp_f[i] = '0; exp_ovf[i] = 0;
            fv_count[i] = 0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (fv[i] === 1'b1) fv_count[i]++;
            if (!rst_n[i]) begin
                m_ok[i] = 1; m_run[i] = 0;
                h1[i] = 0; h2[i] = 0; h3[i] = 0;
                exp_busy[i] = 0; exp_fv[i] = 0; exp_f[i] = '0; exp_ovf[i] = 0;
            end else begin
                // An input rise sampled two edges ago is what gets counted now.
                bit     rise_now;
                longint maxv, sat;
                rise_now = h2[i] & ~h3[i];
                h3[i] = h2[i]; h2[i] = h1[i]; h1[i] = sig[i];
                exp_fv[i] = 0;
                if (m_run[i]) begin
                    m_e[i]++;
                    if (m_e[i] <= gate_of(i) && rise_now) m_cnt[i]++;
                    if (m_e[i] == done_of(i)) begin
                        maxv = (64'd1 << width_of(i)) - 1;
                        sat  = (m_cnt[i] > maxv) ? maxv : m_cnt[i];
                        exp_ovf[i]  = (m_cnt[i] > maxv);
                        exp_f[i]    = BCD ? (exp_ovf[i] ? 32'h9999_9999 : to_bcd(sat))
                                          : 32'(sat);
                        exp_fv[i]   = 1;
                        exp_busy[i] = 0;
                    end else if (m_e[i] == done_of(i) + 1) begin
                        m_run[i] = 0;   // start on this edge is dropped
                    end
                end else if (start[i]) begin
                    m_run[i] = 1; m_e[i] = 0; m_cnt[i] = 0;
                    exp_busy[i] = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (m_ok[i]) begin
                chk($sformatf("busy%0d", i),  32'(busy[i]), 32'(exp_busy[i]));
                chk($sformatf("valid%0d", i), 32'(fv[i]),   32'(exp_fv[i]));
                chk($sformatf("freq%0d", i),  fq[i],        exp_f[i]);
                chk($sformatf("ovf%0d", i),   32'(ovf[i]),  32'(exp_ovf[i]));
            end
        end
    end

    // ---------------- input signal generator ----------------
    int hi_len [NI], lo_len [NI], rem [NI];
    bit rnd [NI], cst [NI], cval [NI];

    initial begin
        sig = '0;
        for (int i = 0; i < NI; i++) begin
            hi_len[i] = 4; lo_len[i] = 4; rem[i] = 1;
            rnd[i] = 0; cst[i] = 0; cval[i] = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NI; i++) begin
                if (cst[i]) begin
                    sig[i] = cval[i];
                end else if (rem[i] <= 1) begin
                    sig[i] = ~sig[i];
                    if (rnd[i]) rem[i] = sig[i] ? $urandom_range(2, 5) : $urandom_range(3, 5);
                    else        rem[i] = sig[i] ? hi_len[i] : lo_len[i];
                end else begin
                    rem[i]--;
                end
            end
        end
    end

    // ---------------- directed + random sequence ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Pulse start, wait (bounded) for freq_valid, check result and latency.
    // Returns in the freq_valid cycle.
    task automatic measure(input int i, input logic [31:0] ef, input bit eo,
                           input int mid_start, input string tag);
        int n;
        int lat_exp;
        lat_exp = BCD ? gate_of(i) + width_of(i) + 2 : gate_of(i) + 1;
        start[i] = 1'b1;
        tick();
        start[i] = 1'b0;
        n = 1;
        while (fv[i] !== 1'b1 && n < lat_exp + 50) begin
            tick();
            n++;
            start[i] = (n == mid_start);
        end
        start[i] = 1'b0;
        if (fv[i] !== 1'b1) begin
            chk({tag, "_timeout"}, 32'(n), 32'(lat_exp));
        end else begin
            chk({tag, "_latency"}, 32'(n), 32'(lat_exp));
            chk({tag, "_freq"}, fq[i], ef);
            chk({tag, "_ovf"}, 32'(ovf[i]), 32'(eo));
        end
    endtask

    initial begin
        int fv_before;
        rst_n = '0;
        start = '0;
        idle(3);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_busy%0d", i),  32'(busy[i]), 32'd0);
            chk($sformatf("rst_valid%0d", i), 32'(fv[i]),   32'd0);
            chk($sformatf("rst_freq%0d", i),  fq[i],        32'd0);
            chk($sformatf("rst_ovf%0d", i),   32'(ovf[i]),  32'd0);
        end
        rst_n = '1;
        idle(20);

        // Period 8 over 800 cycles -> 100 edges.
        measure(0, BCD ? 32'h0000_0100 : 32'd100, 1'b0, -1, "period8");
        $display("txn period8: freq=0x%0h ovf=%0b", fq[0], ovf[0]);
        // Start in the freq_valid cycle is dropped; held high one more cycle it is accepted.
        start[0] = 1'b1;
        tick();
        chk("start_in_done_busy", 32'(busy[0]), 32'd0);
        measure(0, BCD ? 32'h0000_0100 : 32'd100, 1'b0, -1, "restart");
        $display("txn restart: freq=0x%0h ovf=%0b", fq[0], ovf[0]);

        // Constant high input with a second start mid-gate.
        cst[0] = 1; cval[0] = 1;
        idle(10);
        fv_before = fv_count[0];
        measure(0, 32'd0, 1'b0, 400, "const_high");
        idle(2);
        chk("const_high_one_valid", 32'(fv_count[0] - fv_before), 32'd1);
        $display("txn const_high: freq=0x%0h", fq[0]);
        cst[0] = 0;

        // 4-bit counter saturation, then a run that fits.
        hi_len[1] = 4; lo_len[1] = 4;
        idle(10);
        measure(1, BCD ? 32'h9999_9999 : 32'd15, 1'b1, -1, "saturate");
        $display("txn saturate: freq=0x%0h ovf=%0b", fq[1], ovf[1]);
        hi_len[1] = 20; lo_len[1] = 20;
        idle(60);
        measure(1, BCD ? 32'h0000_0005 : 32'd5, 1'b0, -1, "period40");
        $display("txn period40: freq=0x%0h ovf=%0b", fq[1], ovf[1]);

        // Reset 300 cycles into a gate aborts the measurement.
        idle(20);
        fv_before = fv_count[0];
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        idle(299);
        rst_n[0] = 1'b0;
        tick();
        rst_n[0] = 1'b1;
        chk("abort_busy", 32'(busy[0]), 32'd0);
        chk("abort_freq", fq[0], 32'd0);
        idle(900);
        chk("abort_no_valid", 32'(fv_count[0] - fv_before), 32'd0);
        $display("txn abort: busy=%0b freq=0x%0h", busy[0], fq[0]);
        measure(0, BCD ? 32'h0000_0100 : 32'd100, 1'b0, -1, "after_abort");
        $display("txn after_abort: freq=0x%0h", fq[0]);

        // Random inputs, random starts and occasional resets on both meters.
        rnd[0] = 1; rnd[1] = 1;
        for (int c = 0; c < 8000; c++) begin
            for (int i = 0; i < NI; i++) begin
                start[i] = ($urandom_range(0, 39) == 0);
                rst_n[i] = ($urandom_range(0, 2999) != 0);
            end
            tick();
            for (int i = 0; i < NI; i++)
                if (fv[i] === 1'b1)
                    $display("txn random%0d: freq=0x%0h ovf=%0b", i, fq[i], ovf[i]);
        end
        start = '0;
        rst_n = '1;
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
